// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I core-to-IO bridge.
//   state_e         : bridge FSM states
//   IO_SEL_BIT_DEF  : default address bit that selects IO space
//   RD_LAT_DEF      : default IO read latency in cycles
//   mask_wdata()    : zeroes every store byte lane whose enable is low
package rv32i_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int IO_SEL_BIT_DEF = 31;
    localparam int RD_LAT_DEF     = 1;

    function automatic logic [31:0] mask_wdata(input logic [31:0] wdata,
                                               input logic [3:0]  be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = be[b] ? wdata[b*8 +: 8] : 8'h00;
        end
        return m;
    endfunction

endpackage

// File: rtl/rv32i_io_bridge.sv
// Bridges the core data port to a simple registered IO responder.
// Accesses with d_addr[IO_SEL_BIT]=1 stall the core while a single IO
// write or a latency-RD_LAT read is performed; other accesses pass with
// d_ready=1 and never touch the IO side.
//   clk, reset         : clock, asynchronous active-low reset
//   d_req/d_we/d_addr  : core request, direction, byte address
//   d_wdata/d_be       : core store data and byte enables
//   d_ready/d_rdata    : completion strobe and IO load data
//   io_we/io_addr      : IO write strobe and word address
//   io_wdata/io_rdata  : IO write data and registered IO read data
module rv32i_io_bridge
    import rv32i_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int IO_SEL_BIT = IO_SEL_BIT_DEF,
    parameter int RD_LAT     = RD_LAT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [31:0]           d_addr,
    input  logic [31:0]           d_wdata,
    input  logic [3:0]            d_be,
    output logic                  d_ready,
    output logic [31:0]           d_rdata,
    output logic                  io_we,
    output logic [ADDR_WIDTH-1:0] io_addr,
    output logic [31:0]           io_wdata,
    input  logic [31:0]           io_rdata
);

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] io_addr_q, io_addr_d;
    logic [31:0]           io_wdata_q, io_wdata_d;
    logic [31:0]           d_rdata_q, d_rdata_d;
    logic [3:0]            cnt_q, cnt_d;

    logic accept;
    // Only a slice of the byte address reaches the IO side.
    logic unused_addr;
    assign unused_addr = ^d_addr;

    assign accept = d_req && d_addr[IO_SEL_BIT];

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        io_addr_d  = io_addr_q;
        io_wdata_d = io_wdata_q;
        d_rdata_d  = d_rdata_q;
        cnt_d      = cnt_q;
        d_ready    = 1'b0;
        io_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Stall is combinational so the core sees it in the
                // same cycle it presents an IO access.
                d_ready = !accept;
                if (accept) begin
                    io_addr_d  = d_addr[ADDR_WIDTH+1:2];
                    we_d       = d_we;
                    io_wdata_d = mask_wdata(d_wdata, d_be);
                    cnt_d      = 4'(RD_LAT);
                    state_d    = d_we ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                io_we   = we_q;
                state_d = ST_DONE;
            end
            ST_READ: begin
                // Counter reaches zero in the cycle io_rdata becomes
                // valid for the address presented since entry.
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    d_rdata_d = io_rdata;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                d_ready = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            io_addr_q  <= '0;
            io_wdata_q <= '0;
            d_rdata_q  <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            io_addr_q  <= io_addr_d;
            io_wdata_q <= io_wdata_d;
            d_rdata_q  <= d_rdata_d;
            cnt_q      <= cnt_d;
        end
    end

    assign io_addr  = io_addr_q;
    assign io_wdata = io_wdata_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_rv32i_io_bridge.sv
// Self-checking bench: two bridges (RD_LAT=1 and RD_LAT=4) driven with the
// same transactions; each core request line is dropped independently once
// that bridge completes. Expectations come from a transaction-level model:
// completion cycle, masked data, word address and the io_rdata value that
// was on the bus in the sampling cycle.
module tb_rv32i_io_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  d_req;
    logic        d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_be;
    logic [31:0] io_rdata;

    logic [1:0]  d_ready, io_we;
    logic [31:0] d_rdata  [2];
    logic [14:0] io_addr  [2];
    logic [31:0] io_wdata [2];

    int          n_asrt = 0;
    int          n_fail = 0;
    int          lat [2] = '{1, 4};
    logic [31:0] last_rd [2];
    logic [14:0] last_addr;

    always #5 clk = ~clk;

    rv32i_io_bridge #(.ADDR_WIDTH(15), .IO_SEL_BIT(31), .RD_LAT(1)) dut_l1 (
        .clk(clk), .reset(reset), .d_req(d_req[0]), .d_we(d_we),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ready(d_ready[0]), .d_rdata(d_rdata[0]), .io_we(io_we[0]),
        .io_addr(io_addr[0]), .io_wdata(io_wdata[0]), .io_rdata(io_rdata)
    );

    rv32i_io_bridge #(.ADDR_WIDTH(15), .IO_SEL_BIT(31), .RD_LAT(4)) dut_l4 (
        .clk(clk), .reset(reset), .d_req(d_req[1]), .d_we(d_we),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ready(d_ready[1]), .d_rdata(d_rdata[1]), .io_we(io_we[1]),
        .io_addr(io_addr[1]), .io_wdata(io_wdata[1]), .io_rdata(io_rdata)
    );

    task automatic chk(input string tag, input int j,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[lat%0d]: observed %h expected %h", tag, lat[j], obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_mask(input logic [31:0] w, input logic [3:0] be);
        logic [31:0] m = 32'h0;
        for (int b = 0; b < 4; b++)
            if (be[b]) m[b*8 +: 8] = w[b*8 +: 8];
        return m;
    endfunction

    // Called just after a rising edge; returns just after a rising edge.
    task automatic access(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input bit fixed_rd);
        logic [31:0] hist [8];
        int          done [2];
        logic        io;
        logic [31:0] m;
        logic [14:0] a;
        io = addr[31];
        m  = ref_mask(wdata, be);
        a  = addr[16:2];
        d_we = we; d_addr = addr; d_wdata = wdata; d_be = be; d_req = 2'b11;
        for (int j = 0; j < 2; j++)
            done[j] = !io ? -1 : (we ? 2 : lat[j] + 2);
        for (int k = 0; k < 8; k++) begin
            hist[k]  = fixed_rd ? 32'h1 : $urandom;
            io_rdata = hist[k];
            @(negedge clk);
            for (int j = 0; j < 2; j++) begin
                if (!io) begin
                    chk("nonio_ready", j, 32'(d_ready[j]), 32'd1);
                    chk("nonio_we",    j, 32'(io_we[j]),   32'd0);
                    chk("nonio_addr",  j, 32'(io_addr[j]), 32'(last_addr));
                    chk("nonio_rdata", j, d_rdata[j],      last_rd[j]);
                end else if (k < done[j]) begin
                    chk("busy_ready", j, 32'(d_ready[j]), 32'd0);
                    chk("busy_we",    j, 32'(io_we[j]),   32'(we && k == 1));
                    if (k >= 1) chk("busy_addr", j, 32'(io_addr[j]), 32'(a));
                    if (we && k == 1) chk("wr_data", j, io_wdata[j], m);
                end else if (k == done[j]) begin
                    if (!we) last_rd[j] = hist[lat[j] + 1];
                    chk("done_ready", j, 32'(d_ready[j]), 32'd1);
                    chk("done_we",    j, 32'(io_we[j]),   32'd0);
                    chk("done_rdata", j, d_rdata[j],      last_rd[j]);
                    chk("done_addr",  j, 32'(io_addr[j]), 32'(a));
                end else begin
                    chk("post_ready", j, 32'(d_ready[j]), 32'd1);
                    chk("post_we",    j, 32'(io_we[j]),   32'd0);
                    chk("post_addr",  j, 32'(io_addr[j]), 32'(a));
                end
            end
            @(posedge clk); #1;
            for (int j = 0; j < 2; j++)
                if (!io || k == done[j]) d_req[j] = 1'b0;
        end
        if (io) last_addr = a;
    endtask

    initial begin
        reset = 1'b0; d_req = 2'b00; d_we = 1'b0; d_addr = '0;
        d_wdata = '0; d_be = '0; io_rdata = '0;
        last_rd = '{32'h0, 32'h0}; last_addr = '0;
        #3;
        for (int j = 0; j < 2; j++) begin
            chk("rst_we",    j, 32'(io_we[j]),   32'd0);
            chk("rst_addr",  j, 32'(io_addr[j]), 32'd0);
            chk("rst_wdata", j, io_wdata[j],     32'd0);
            chk("rst_rdata", j, d_rdata[j],      32'd0);
            chk("rst_ready", j, 32'(d_ready[j]), 32'd1);
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;

        access(1'b1, 32'h8000_0004, 32'h0000_03A5, 4'hF, 1'b0);
        access(1'b0, 32'h8000_0000, 32'h0,         4'hF, 1'b1);
        access(1'b1, 32'h8000_0008, 32'hDEAD_BEEF, 4'b0001, 1'b0);
        access(1'b0, 32'h0000_0100, 32'h1234_5678, 4'hF, 1'b0);
        access(1'b1, 32'h0000_0100, 32'h1234_5678, 4'hF, 1'b0);
        access(1'b1, 32'h8001_FFFC, 32'hA5A5_5A5A, 4'b1010, 1'b0);

        for (int t = 0; t < 40; t++) begin
            access(1'($urandom_range(0, 1)),
                   {($urandom_range(0, 3) != 0), 31'($urandom)},
                   $urandom, 4'($urandom), 1'b0);
        end

        // Reset in cycle 1 of a read abandons it immediately.
        d_we = 1'b0; d_addr = 32'h8000_0010; d_req = 2'b11; io_rdata = $urandom;
        @(posedge clk); #1 reset = 1'b0;
        #1;
        for (int j = 0; j < 2; j++) begin
            chk("mid_rst_we",    j, 32'(io_we[j]),   32'd0);
            chk("mid_rst_addr",  j, 32'(io_addr[j]), 32'd0);
            chk("mid_rst_wdata", j, io_wdata[j],     32'd0);
            chk("mid_rst_rdata", j, d_rdata[j],      32'd0);
            chk("mid_rst_stall", j, 32'(d_ready[j]), 32'd0);
        end
        d_req = 2'b00;
        #1;
        for (int j = 0; j < 2; j++)
            chk("mid_rst_idle", j, 32'(d_ready[j]), 32'd1);
        @(posedge clk); #1 reset = 1'b1;
        last_rd = '{32'h0, 32'h0}; last_addr = '0;
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            chk("rel_ready", j, 32'(d_ready[j]), 32'd1);
            chk("rel_we",    j, 32'(io_we[j]),   32'd0);
        end
        @(posedge clk); #1;

        access(1'b0, 32'h8000_0010, 32'h0, 4'hF, 1'b0);
        access(1'b1, 32'h8000_0020, 32'hCAFE_F00D, 4'b1100, 1'b0);
        access(1'b0, 32'h0000_0020, 32'h0, 4'hF, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32i_io_bridge.md
RV32I_IO_BRIDGE -- requirements
Module: rv32i_io_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, default 15: width of io_addr, a word address.
REQ-002 Parameter IO_SEL_BIT, default 31: a core address is IO space when d_addr[IO_SEL_BIT]=1.
REQ-003 Parameter RD_LAT, default 1, legal range 1..15: cycles between io_addr presentation and valid io_rdata.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 d_req  in  1  core data access request, held until d_ready.
REQ-007 d_we  in  1  core write=1, read=0.
REQ-008 d_addr  in  32  core byte address.
REQ-009 d_wdata  in  32  core store data.
REQ-010 d_be  in  4  core byte enables.
REQ-011 d_ready  out  1  access complete, or no IO stall.
REQ-012 d_rdata  out  32  IO load data.
REQ-013 io_we  out  1  IO write strobe to the IO responder.
REQ-014 io_addr  out  ADDR_WIDTH  IO word address.
REQ-015 io_wdata  out  32  IO write data.
REQ-016 io_rdata  in  32  IO read data, registered by the responder.

Function
REQ-017 FSM states SHALL be IDLE, WRITE, READ, DONE.
REQ-018 IDLE, d_req=0 or d_addr[IO_SEL_BIT]=0: d_ready=1, io_we=0, no state change.
REQ-019 IDLE, d_req=1 and d_addr[IO_SEL_BIT]=1: d_ready=0 combinationally; capture d_addr[ADDR_WIDTH+1:2], d_we, and masked write data; go to WRITE if d_we=1, else READ.
REQ-020 Masked write data SHALL be d_wdata with every byte lane whose d_be bit is 0 forced to 8'h00.
REQ-021 WRITE: io_we=1 for exactly one cycle; io_addr/io_wdata from the captured registers; d_ready=0; next state DONE.
REQ-022 READ: io_we=0; io_addr held; wait counter loaded with RD_LAT on entry and decremented each cycle while nonzero.
REQ-023 READ with counter=0: sample io_rdata into the d_rdata register at that edge; next state DONE.
REQ-024 DONE: d_ready=1 for exactly one cycle; next state IDLE; no new request accepted in DONE.
REQ-025 d_rdata SHALL hold the last sampled read value until the next IO read completes; IO writes do not alter it.
REQ-026 io_addr/io_wdata SHALL hold their last values outside WRITE/READ; io_we SHALL be 1 only in WRITE.
REQ-027 Latency: request in cycle 0 gives write completion (d_ready) in cycle 2 and read completion in cycle RD_LAT+2.
REQ-028 A core request with d_addr[IO_SEL_BIT]=0 SHALL never assert io_we or change io_addr.

Reset
REQ-029 reset=0 SHALL immediately force state IDLE, io_we=0, io_addr=0, io_wdata=0, d_rdata=0, and wait counter=0, including mid-transaction.
REQ-030 After reset release the in-flight access SHALL be abandoned; the core re-issues it.

Structure
REQ-031 The FSM state enum and the default values of IO_SEL_BIT and RD_LAT SHALL live in shared package rv32i_pkg.
REQ-032 The block SHALL be a single flat module with no sub-modules.

Verification
REQ-033 IO write: d_req=1, d_we=1, d_addr=32'h8000_0004, d_wdata=32'h0000_03A5, d_be=4'hF -> cycle 1: io_we=1, io_addr=1, io_wdata=32'h3A5; cycle 2: d_ready=1.
REQ-034 IO read, RD_LAT=1: d_addr=32'h8000_0000, io_rdata=32'h1 -> io_addr=0 in cycles 1-2; cycle 3: d_ready=1, d_rdata=32'h1.
REQ-035 Partial write: d_be=4'b0001, d_wdata=32'hDEAD_BEEF -> io_wdata=32'h0000_00EF.
REQ-036 Non-IO access: d_addr=32'h0000_0100, d_req=1 -> d_ready=1 every cycle; io_we stays 0; io_addr unchanged.
REQ-037 Reset mid-read: assert reset=0 in cycle 1 of a read -> io_we=0 and state IDLE immediately; after release, d_ready=1 with d_req=0.
REQ-038 RD_LAT=4 read -> d_ready first rises in cycle 6 and is high for exactly one cycle.
